io_uart_tx_port: RTL and testbench
==================================

Name: io_uart_tx_port

Overview:
Memory-mapped UART transmitter that responds on the stack-machine CPU I/O bus: `io_addr`, `io_rd_data`, `io_write`, `io_wr_data`.
- The CPU stores bytes into a small TX FIFO and polls a status register.
- The block serialises each byte as 8N1, LSB first, on `tx`.
- It decodes only its own address window. When not selected it drives 0 on `io_rd_data`, so several peripherals can be OR-combined on the CPU read bus.

Parameters:
- WIDTH, 16, CPU data/address width. Must match the CPU width.
- BASE_ADDR, 16'h4000, window base. Must be 16-aligned with top two bits nonzero, i.e. in the CPU I/O region.
- FIFO_DEPTH, 4, TX FIFO entries. Power of two, 2..16.
- DEFAULT_DIV, 217, reset value of the baud divisor in clocks per bit (25 MHz / 115200).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- io_addr  input  WIDTH  CPU I/O address; valid every cycle
- io_rd_data  output  WIDTH  read data, combinational from `io_addr`
- io_write  input  1  one-cycle write strobe
- io_wr_data  input  WIDTH  write data, qualified by `io_write`
- tx  output  1  serial output; idles high
- tx_idle  output  1  high when FIFO is empty and the FSM is in IDLE

Behaviour:

Address decode:
- `sel` = (io_addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]).
- Offset = io_addr[1:0]. Offset 3 and io_addr[3:2] != 0 are reserved: reads return 0, writes are ignored.

Reads (combinational, same cycle; the CPU samples at the clock edge that ends its load):
- Offset 0 (DATA): returns 0.
- Offset 1 (STATUS): {zeros, overflow[3], fifo_full[2], fifo_empty[1], busy[0]}.
- Offset 2 (DIV): returns the divisor register, zero-extended.
- `!sel`: `io_rd_data` = 0.
- Reads have no side effects.

Writes (registered on the rising clock edge when `io_write & sel`):
- Offset 0 (DATA): push io_wr_data[7:0] into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and sticky `overflow` is set.
  - A push and pop in the same cycle on a full FIFO is accepted.
- Offset 1 (STATUS): io_wr_data[3]=1 clears `overflow`. Other bits are ignored.
- Offset 2 (DIV): load the 16-bit divisor. A value of 0 is treated as 1.

Reset values:
- tx=1, tx_idle=1.
- FIFO empty, overflow=0, divisor=DEFAULT_DIV.
- FSM=IDLE, bit counter and baud counter = 0.
- `io_rd_data` is combinational and has no reset value.
- Reset mid-frame aborts the frame: tx returns high immediately and FIFO contents are lost.

TX FSM, states IDLE, START, DATA, STOP:
- IDLE: tx=1. If the FIFO is not empty, pop the head into an 8-bit shift register, load the baud counter with `divisor`, and go to START on the next edge.
- START: tx=0 for `divisor` clocks.
- DATA: tx=shift[0] for `divisor` clocks per bit. Shift right at each bit boundary; 8 bits; bit index counts 0..7.
- STOP: tx=1 for `divisor` clocks.
  - At the end of STOP, if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- Frame length is exactly 10×divisor clocks.
- The baud counter reloads from the current divisor register at every bit boundary, so a DIV write mid-frame takes effect from the next bit.
- busy = (state != IDLE).
- tx_idle = !busy & fifo_empty.
- tx is driven from a register (glitch-free).

FIFO:
- Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_full = (count == FIFO_DEPTH); fifo_empty = (count == 0).

Test Plan:
- Reset, then read offsets 1 and 2 → STATUS=16'h0002, DIV=16'd217, tx=1, tx_idle=1; a read at 16'h0000 → 0.
- DIV=4, write 8'hA5 to DATA → tx goes low 1 cycle after the write edge. Bits sampled mid-bit: start=0, then 1,0,1,0,0,1,0,1, stop=1. Total 40 clocks; tx_idle rises after the stop bit.
- DIV=4, write 4 bytes back-to-back (8'h01..8'h04) → frames are contiguous: the next start bit follows the stop bit with 0 idle cycles, total 160 clocks, STATUS.busy=1 throughout.
- DIV=100, write 6 bytes in consecutive cycles while the first is transmitting:
  - After byte 1 is popped, bytes 2..5 fill the FIFO and byte 6 is dropped; STATUS reads 16'h000D (overflow|full|busy).
  - Write STATUS with bit 3 set → overflow=0.
  - Exactly 5 frames are emitted.
- DIV=4, write DIV=8 during the DATA bit 3 phase → bits 0-3 last 4 clocks each; bits 4-7 and stop last 8 clocks each.
- Assert reset during DATA bit 5 with 2 bytes queued → tx=1 immediately, STATUS=16'h0002 after release, no further frames are emitted.

Source files
------------

// File: rtl/io_uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter for the stack-machine CPU I/O bus.
// The CPU pushes bytes into a small TX FIFO through the DATA register.
// It polls STATUS and sets the baud divisor through DIV.
// Outside its 16-byte address window the block returns 0 on io_rd_data,
// so the read buses of several peripherals can simply be OR-ed together.
module io_uart_tx_port #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] BASE_ADDR   = 16'h4000,
    parameter int               FIFO_DEPTH  = 4,
    parameter int               DEFAULT_DIV = 217
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_addr,
    output logic [WIDTH-1:0] io_rd_data,
    input  logic             io_write,
    input  logic [WIDTH-1:0] io_wr_data,
    output logic             tx,
    output logic             tx_idle
);

    localparam int             PTR_W      = $clog2(FIFO_DEPTH);
    localparam int             CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]    RESET_DIV  = 16'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------- address decode ----------------
    logic       sel;
    logic       reg_ok;
    logic [1:0] offset;
    logic       wr_data_en;
    logic       wr_status_en;
    logic       wr_div_en;

    assign sel          = (io_addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
    // io_addr[3:2] != 0 aliases are reserved and behave like offset 3
    assign reg_ok       = sel && (io_addr[3:2] == 2'b00);
    assign offset       = io_addr[1:0];
    assign wr_data_en   = io_write && reg_ok && (offset == 2'd0);
    assign wr_status_en = io_write && reg_ok && (offset == 2'd1);
    assign wr_div_en    = io_write && reg_ok && (offset == 2'd2);

    // ---------------- registers ----------------
    logic [15:0]      div_reg;
    logic             overflow_reg;

    logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             push_ok;
    logic             pop;

    state_t           state_reg;
    state_t           state_next;
    logic [15:0]      baud_reg;
    logic [15:0]      baud_next;
    logic [2:0]       bit_idx_reg;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             tx_reg;
    logic             tx_next;
    logic             bit_done;
    logic             busy;

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    // A full FIFO still accepts a byte when the FSM pops in the same cycle
    assign push_ok    = wr_data_en && (!fifo_full || pop);
    assign bit_done   = (baud_reg == 16'd1);
    assign busy       = (state_reg != S_IDLE);
    assign tx_idle    = !busy && fifo_empty;
    assign tx         = tx_reg;

    // Register read mux; everything unselected or reserved reads as zero
    always_comb begin
        io_rd_data = '0;
        if (reg_ok) begin
            case (offset)
                2'd1:    io_rd_data[3:0]  = {overflow_reg, fifo_full, fifo_empty, busy};
                2'd2:    io_rd_data[15:0] = div_reg;
                default: io_rd_data       = '0;
            endcase
        end
    end

    // Baud divisor; zero would stall the bit timer, so it is stored as one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_reg <= RESET_DIV;
        end else if (wr_div_en) begin
            div_reg <= (io_wr_data[15:0] == 16'd0) ? 16'd1 : io_wr_data[15:0];
        end
    end

    // Sticky overflow: set on a dropped byte, cleared by writing STATUS bit 3
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (wr_data_en && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end else if (wr_status_en && io_wr_data[3]) begin
            overflow_reg <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= io_wr_data[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    // TX FSM state, bit timer, shifter and registered serial output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            baud_reg    <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    // Next-state logic: the bit timer reloads from div_reg at every bit boundary
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        tx_next      = 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_head;
                    baud_next    = div_reg;
                    bit_idx_next = 3'd0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_next    = div_reg;
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_next  = div_reg;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        // back-to-back frame: no idle gap after the stop bit
                        pop          = 1'b1;
                        shift_next   = fifo_head;
                        baud_next    = div_reg;
                        bit_idx_next = 3'd0;
                        state_next   = S_START;
                    end else begin
                        baud_next  = 16'd0;
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The line level follows the state being entered, so tx is registered
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_io_uart_tx_port.sv
// Directed bench for io_uart_tx_port: a table of register access vectors
// followed by hand-written multi-cycle sequences.
// The tx, tx_idle and io_rd_data outputs are logged once per clock on the
// falling edge. Frames are then checked sample by sample against the
// expected bit levels and durations.
module tb_io_uart_tx_port;

    localparam int MAXC = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] io_addr = 16'h0000;
    logic [15:0] io_rd_data;
    logic        io_write = 1'b0;
    logic [15:0] io_wr_data = 16'h0000;
    logic        tx;
    logic        tx_idle;

    io_uart_tx_port #(
        .WIDTH      (16),
        .BASE_ADDR  (16'h4000),
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(217)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_addr   (io_addr),
        .io_rd_data(io_rd_data),
        .io_write  (io_write),
        .io_wr_data(io_wr_data),
        .tx        (tx),
        .tx_idle   (tx_idle)
    );

    always #5 clock = ~clock;

    // per-cycle output log, sampled away from the active edge
    int          cyc = 0;
    logic        tx_hist   [MAXC];
    logic        idle_hist [MAXC];
    logic [15:0] rd_hist   [MAXC];

    always @(negedge clock) begin
        if (cyc < MAXC) begin
            tx_hist[cyc]   <= tx;
            idle_hist[cyc] <= tx_idle;
            rd_hist[cyc]   <= io_rd_data;
        end
        cyc <= cyc + 1;
    end

    int vec_count  = 0;
    int miss_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("  ok %s = %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        io_addr    = a;
        io_wr_data = d;
        io_write   = 1'b1;
        @(posedge clock);
        #1;
        io_write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        io_addr = a;
        #1;
        d = io_rd_data;
    endtask

    // sel: 0 = tx, 1 = tx_idle, 2 = STATUS.busy (io_rd_data[0])
    function automatic int count_bad(input int from, input int to, input int sel, input logic exp);
        int   bad;
        logic v;
        bad = 0;
        for (int i = from; i <= to; i++) begin
            if (i < 0 || i >= MAXC) begin
                bad++;
            end else begin
                case (sel)
                    0:       v = tx_hist[i];
                    1:       v = idle_hist[i];
                    default: v = rd_hist[i][0];
                endcase
                if (v !== exp) bad++;
            end
        end
        return bad;
    endfunction

    // Frame of 10 bits starting at sample s; bits with index >= chg last d1 clocks
    task automatic check_frame(input string name, input int s, input logic [7:0] b,
                               input int d0, input int d1, input int chg);
        int   p;
        int   d;
        int   bad;
        logic lv;
        p = s;
        for (int k = 0; k < 10; k++) begin
            d  = (k < chg) ? d0 : d1;
            lv = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
            bad = count_bad(p, p + d - 1, 0, lv);
            check($sformatf("%s bit%0d bad samples", name, k), bad, 0);
            p += d;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] raddr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [15:0] rd;
        int c0;
        int c1;
        int s;
        logic [7:0] b4 [5];

        vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 16'h4001, 16'h0002};
        vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h4002, 16'h00D9};
        vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h4000, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h4003, 16'h0000};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h4005, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h4011, 16'h0000};
        vecs[7]  = '{1'b1, 16'h4006, 16'h0005, 16'h4002, 16'h00D9};
        vecs[8]  = '{1'b1, 16'h4002, 16'h0000, 16'h4002, 16'h0001};
        vecs[9]  = '{1'b1, 16'h4002, 16'h1234, 16'h4002, 16'h1234};
        vecs[10] = '{1'b1, 16'h4012, 16'h0009, 16'h4002, 16'h1234};
        vecs[11] = '{1'b1, 16'h4001, 16'h0008, 16'h4001, 16'h0002};
        vecs[12] = '{1'b1, 16'h4002, 16'h0004, 16'h4002, 16'h0004};

        // ---- reset ----
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check("reset tx", tx, 1'b1);
        check("reset tx_idle", tx_idle, 1'b1);

        // ---- register access table ----
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d rd[%h]", i, vecs[i].raddr), rd, vecs[i].exp);
            tick(1);
        end

        // ---- single frame 0xA5 at DIV=4 ----
        bus_write(16'h4000, 16'h00A5);
        c0 = cyc;
        io_addr = 16'h4001;
        tick(50);
        check("A5 tx high on write edge", tx_hist[c0], 1'b1);
        check_frame("A5", c0 + 1, 8'hA5, 4, 4, 10);
        check("A5 tx_idle during stop", idle_hist[c0 + 40], 1'b0);
        check("A5 tx_idle after stop", idle_hist[c0 + 41], 1'b1);
        check("A5 status after frame", rd_hist[c0 + 41], 16'h0002);

        // ---- four back-to-back frames ----
        bus_write(16'h4000, 16'h0001);
        c0 = cyc;
        bus_write(16'h4000, 16'h0002);
        bus_write(16'h4000, 16'h0003);
        bus_write(16'h4000, 16'h0004);
        io_addr = 16'h4001;
        c1 = cyc;
        tick(170);
        for (int k = 0; k < 4; k++) begin
            check_frame($sformatf("b2b%0d", k), c0 + 1 + 40 * k, 8'(k + 1), 4, 4, 10);
        end
        check("b2b busy gaps", count_bad(c1, c0 + 160, 2, 1'b1), 0);
        check("b2b idle after 160", idle_hist[c0 + 161], 1'b1);
        check("b2b status after", rd_hist[c0 + 161], 16'h0002);

        // ---- overflow at DIV=100 ----
        b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44; b4[4] = 8'h55;
        bus_write(16'h4002, 16'd100);
        bus_write(16'h4000, 16'h0011);
        c0 = cyc;
        bus_write(16'h4000, 16'h0022);
        bus_write(16'h4000, 16'h0033);
        bus_write(16'h4000, 16'h0044);
        bus_write(16'h4000, 16'h0055);
        bus_write(16'h4000, 16'h0066);
        bus_read(16'h4001, rd);
        check("ovf status", rd, 16'h000D);
        tick(1);
        bus_write(16'h4001, 16'h0008);
        bus_read(16'h4001, rd);
        check("ovf cleared status", rd, 16'h0005);
        io_addr = 16'h4001;
        tick(5100);
        for (int k = 0; k < 5; k++) begin
            check_frame($sformatf("ovf%0d", k), c0 + 1 + 1000 * k, b4[k], 100, 100, 10);
        end
        check("ovf no sixth frame", count_bad(c0 + 1001 + 4000, c0 + 5090, 0, 1'b1), 0);
        check("ovf idle after 5", count_bad(c0 + 5001, c0 + 5090, 1, 1'b1), 0);
        check("ovf status end", rd_hist[c0 + 5001], 16'h0002);

        // ---- divisor change during data bit 3 ----
        bus_write(16'h4002, 16'd4);
        bus_write(16'h4000, 16'h003C);
        c0 = cyc;
        s  = c0 + 1;
        tick(17);
        bus_write(16'h4002, 16'd8);
        io_addr = 16'h4001;
        tick(80);
        check_frame("divchg", s, 8'h3C, 4, 8, 5);
        check("divchg busy at end", idle_hist[s + 59], 1'b0);
        check("divchg idle after", idle_hist[s + 60], 1'b1);

        // ---- reset during data bit 5 with two bytes queued ----
        bus_write(16'h4002, 16'd4);
        bus_write(16'h4000, 16'h0081);
        c0 = cyc;
        bus_write(16'h4000, 16'h0082);
        bus_write(16'h4000, 16'h0083);
        io_addr = 16'h4001;
        tick(24);
        check("rst tx in bit5", tx, 1'b0);
        reset = 1'b1;
        #1;
        check("rst tx immediate", tx, 1'b1);
        check("rst tx_idle immediate", tx_idle, 1'b1);
        tick(2);
        reset = 1'b0;
        bus_read(16'h4001, rd);
        check("rst status", rd, 16'h0002);
        bus_read(16'h4002, rd);
        check("rst div", rd, 16'h00D9);
        io_addr = 16'h4001;
        c1 = cyc;
        tick(100);
        check("rst no frames", count_bad(c1, c1 + 95, 0, 1'b1), 0);
        check("rst stays idle", count_bad(c1, c1 + 95, 1, 1'b1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
